// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus sequencer.
// The package carries the bus-cycle state encoding, the default phase
// widths, and the sizing helpers used by the sequencer and its arbiter.
package rtc_bus_pkg;

  // Bus-cycle phases: address strobe, address hold, data strobe, recovery.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADR   = 3'd1,
    AHOLD = 3'd2,
    DAT   = 3'd3,
    RCV   = 3'd4
  } rtc_state_e;

  localparam int RTC_T_PULSE_DEF = 4;
  localparam int RTC_T_GAP_DEF   = 2;

  // Width of the shared phase down-counter; it must hold max(T_PULSE, T_GAP)-1.
  function automatic int rtc_cnt_width(input int t_pulse, input int t_gap);
    int t_max;
    t_max = (t_pulse > t_gap) ? t_pulse : t_gap;
    return (t_max < 1) ? 1 : $clog2(t_max + 1);
  endfunction

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int rtc_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Requester-side handshake and RTC pin-side signals of the bus sequencer.
// The slave modport is the sequencer; the master modport is the
// surroundings (access engines plus the pad/tristate logic).
interface rtc_bus_sequencer_if #(
  parameter int NREQ = 3,
  parameter int DW   = 8
);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*DW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic               cs;
  logic               rd;
  logic               wr;
  logic               ad;
  logic [DW-1:0]      bus_out;
  logic               bus_oe;
  logic [DW-1:0]      bus_in;

  modport slave (
    input  req, we, addr, wdata, bus_in,
    output done, rdata, grant, busy, cs, rd, wr, ad, bus_out, bus_oe
  );

  modport master (
    output req, we, addr, wdata, bus_in,
    input  done, rdata, grant, busy, cs, rd, wr, ad, bus_out, bus_oe
  );

endinterface

// File: rtl/rtc_rr_arbiter.sv
// Combinational requester arbiter for the RTC bus sequencer.
// Default build: round-robin, the search starts at ptr_i.
// With RTC_FIXED_PRIO_EN defined: fixed priority, lowest index wins and
// ptr_i is ignored.
module rtc_rr_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int NREQ = 3,
  localparam int IW  = rtc_idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW-1:0] cand;

`ifdef RTC_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
`endif

  // Scan candidates in priority order and keep only the first asserted one.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef RTC_FIXED_PRIO_EN
      cand = IW'(i);
`else
      cand = (int'(ptr_i) + i >= NREQ) ? IW'(int'(ptr_i) + i - NREQ)
                                       : IW'(int'(ptr_i) + i);
`endif
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Arbitrates the RTC access engines for the shared multiplexed AD bus and
// runs each granted transaction as one complete Intel-style bus cycle:
// ADR (cs/ad/wr low, address driven), AHOLD, DAT (wr or rd low), RCV.
// Every output is registered and is decoded from the next state.
// Build option RTC_FIXED_PRIO_EN selects fixed priority instead of
// round-robin; the pointer register only exists in the round-robin build.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int DW      = 8,
  parameter int T_PULSE = RTC_T_PULSE_DEF,
  parameter int T_GAP   = RTC_T_GAP_DEF
) (
  input  logic clk,
  input  logic rst_n,
  rtc_bus_sequencer_if.slave bus
);

  localparam int CW = rtc_cnt_width(T_PULSE, T_GAP);
  localparam int IW = rtc_idx_width(NREQ);
  localparam logic [CW-1:0] PULSE_LD = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(T_GAP - 1);

  rtc_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            busy_q, busy_d;
  logic            cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, ad_q, ad_d;
  logic            oe_q, oe_d;
  logic [DW-1:0]   bout_q, bout_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic [IW-1:0]   arb_ptr;

  rtc_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (bus.req),
    .ptr_i (arb_ptr),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

`ifdef RTC_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [IW-1:0] ptr_q, ptr_d;
  assign arb_ptr = ptr_q;

  // Round-robin pointer moves just past the winner whenever a grant is made.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && arb_any) begin
      ptr_d = (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  // Phase sequencing: one down-counter reloaded on every phase entry; the
  // winner's request fields are captured at grant and held to the end.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (arb_any) begin
          state_d = ADR;
          cnt_d   = PULSE_LD;
          grant_d = arb_gnt;
          we_d    = bus.we[arb_idx];
          addr_d  = bus.addr[arb_idx*DW +: DW];
          wdata_d = bus.wdata[arb_idx*DW +: DW];
        end
      end
      ADR: begin
        if (cnt_q == '0) begin
          state_d = AHOLD;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      AHOLD: begin
        if (cnt_q == '0) begin
          state_d = DAT;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DAT: begin
        if (cnt_q == '0) begin
          state_d = RCV;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RCV: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          grant_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        grant_d = '0;
      end
    endcase
  end

  // Output decode from the next state so every pin changes on the same edge
  // as the phase itself; rdata samples the bus at the end of a read DAT.
  always_comb begin
    cs_d    = 1'b1;
    rd_d    = 1'b1;
    wr_d    = 1'b1;
    ad_d    = 1'b1;
    oe_d    = 1'b0;
    bout_d  = '0;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == RCV && cnt_d == '0) ? grant_d : '0;
    rdata_d = (state_q == DAT && cnt_q == '0 && !we_q) ? bus.bus_in : rdata_q;
    case (state_d)
      ADR: begin
        cs_d   = 1'b0;
        ad_d   = 1'b0;
        wr_d   = 1'b0;
        oe_d   = 1'b1;
        bout_d = addr_d;
      end
      AHOLD: begin
        cs_d   = 1'b0;
        oe_d   = 1'b1;
        bout_d = addr_d;
      end
      DAT: begin
        cs_d = 1'b0;
        if (we_d) begin
          wr_d   = 1'b0;
          oe_d   = 1'b1;
          bout_d = wdata_d;
        end else begin
          rd_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // State, captured request and registered pins; reset aborts any cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      ad_q    <= 1'b1;
      oe_q    <= 1'b0;
      bout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ad_q    <= ad_d;
      oe_q    <= oe_d;
      bout_q  <= bout_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = busy_q;
  assign bus.cs      = cs_q;
  assign bus.rd      = rd_q;
  assign bus.wr      = wr_q;
  assign bus.ad      = ad_q;
  assign bus.bus_oe  = oe_q;
  assign bus.bus_out = bout_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer: a default-timing instance for
// directed scenarios and a T_PULSE=T_GAP=1 instance for a random soak.
// Expected pin traces come from a phase model computed from cycle offsets.
module tb_rtc_bus_sequencer;

  localparam int NREQ = 3;
  localparam int DW   = 8;
  localparam int TP   = 4;
  localparam int TG   = 2;
  localparam int TXN  = 2*TP + 2*TG;
  localparam int FTP  = 1;
  localparam int FTG  = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rtc_bus_sequencer_if #(.NREQ(NREQ), .DW(DW)) bi ();
  rtc_bus_sequencer_if #(.NREQ(NREQ), .DW(DW)) bf ();

  rtc_bus_sequencer #(.NREQ(NREQ), .DW(DW), .T_PULSE(TP), .T_GAP(TG)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bi.slave));

  rtc_bus_sequencer #(.NREQ(NREQ), .DW(DW), .T_PULSE(FTP), .T_GAP(FTG)) dut_f (
    .clk(clk), .rst_n(rst_n), .bus(bf.slave));

  int n_cmp = 0;
  int n_bad = 0;
  int m_ptr = 0;
  int f_ptr = 0;

  logic [19:0] trace [0:TXN+1];
  logic [7:0]  rdata_at_done;

  // Packed pin snapshot: {cs,rd,wr,ad,oe,busy,grant[2:0],done[2:0],bus_out[7:0]}
  function automatic logic [19:0] obs_main();
    return {bi.cs, bi.rd, bi.wr, bi.ad, bi.bus_oe, bi.busy, bi.grant, bi.done, bi.bus_out};
  endfunction

  function automatic logic [19:0] obs_fast();
    return {bf.cs, bf.rd, bf.wr, bf.ad, bf.bus_oe, bf.busy, bf.grant, bf.done, bf.bus_out};
  endfunction

  // bus_out is only meaningful while the bus is driven.
  function automatic logic [19:0] cmp_mask(input logic [19:0] e);
    return e[15] ? 20'hFFFFF : 20'hFFF00;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Expected pins k cycles after the grant edge (k=1 is the first ADR cycle).
  function automatic logic [19:0] exp_obs(input int k, input int r, input logic w,
                                          input logic [7:0] a, input logic [7:0] d);
    int ph;
    logic cs, rd, wr, ad, oe, bsy;
    logic [NREQ-1:0] g, dn;
    logic [7:0] bo;
    if      (k <= TP)          ph = 0;
    else if (k <= TP + TG)     ph = 1;
    else if (k <= 2*TP + TG)   ph = 2;
    else if (k <= TXN)         ph = 3;
    else                       ph = 4;
    cs  = (ph >= 3);
    ad  = (ph != 0);
    wr  = !(ph == 0 || (ph == 2 && w));
    rd  = !(ph == 2 && !w);
    oe  = (ph <= 1) || (ph == 2 && w);
    bsy = (ph != 4);
    g   = (ph != 4) ? onehot(r) : '0;
    dn  = (k == TXN) ? onehot(r) : '0;
    bo  = (ph <= 1) ? a : ((ph == 2 && w) ? d : 8'h00);
    return {cs, rd, wr, ad, oe, bsy, g, dn, bo};
  endfunction

  // Arbitration as described: first requester found scanning from the pointer.
  function automatic int model_winner(input logic [NREQ-1:0] r, input int ptr);
    int c;
    for (int i = 0; i < NREQ; i++) begin
`ifdef RTC_FIXED_PRIO_EN
      c = i + 0*ptr;
`else
      c = (ptr + i) % NREQ;
`endif
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    bi.req = '0; bi.we = '0; bi.addr = '0; bi.wdata = '0; bi.bus_in = '0;
    bf.req = '0; bf.we = '0; bf.addr = '0; bf.wdata = '0; bf.bus_in = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    f_ptr = 0;
    @(negedge clk);
  endtask

  // Drive one request on the main instance and record TXN+1 cycles of pins.
  task automatic run_txn(input int r, input logic w, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] bin, input int drop_at);
    bi.we[r] = w;
    bi.addr[r*DW +: DW]  = a;
    bi.wdata[r*DW +: DW] = d;
    bi.bus_in = bin;
    bi.req[r] = 1'b1;
    m_ptr = (r + 1) % NREQ;
    for (int k = 1; k <= TXN + 1; k++) begin
      @(negedge clk);
      trace[k] = obs_main();
      if (k == TXN) rdata_at_done = bi.rdata;
      if (bi.done[r]) bi.req[r] = 1'b0;
      if (k == drop_at) begin
        bi.req[r] = 1'b0;
        bi.addr[r*DW +: DW]  = ~a;
        bi.wdata[r*DW +: DW] = ~d;
      end
    end
  endtask

  task automatic test_reset();
    logic [19:0] idle_e;
    idle_e = exp_obs(TXN + 1, 0, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs_main() !== idle_e) begin
      n_bad++; $display("FAIL reset_pins: got %h expected %h", obs_main(), idle_e);
    end
    n_cmp++;
    if (bi.rdata !== 8'h00) begin
      n_bad++; $display("FAIL reset_rdata: got %h expected 00", bi.rdata);
    end
    n_cmp++;
    if (obs_fast() !== idle_e) begin
      n_bad++; $display("FAIL reset_pins_fast: got %h expected %h", obs_fast(), idle_e);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ((obs_main() & cmp_mask(idle_e)) !== (idle_e & cmp_mask(idle_e))) begin
      n_bad++; $display("FAIL idle_after_reset: got %h expected %h", obs_main(), idle_e);
    end
    m_ptr = 0;
    f_ptr = 0;
  endtask

  task automatic test_single_write();
    logic [19:0] e;
    apply_reset();
    run_txn(0, 1'b1, 8'h0A, 8'h26, 8'h00, 0);
    for (int k = 1; k <= TXN + 1; k++) begin
      e = exp_obs(k, 0, 1'b1, 8'h0A, 8'h26);
      n_cmp++;
      if ((trace[k] & cmp_mask(e)) !== (e & cmp_mask(e))) begin
        n_bad++; $display("FAIL write_cycle%0d: got %h expected %h", k, trace[k], e);
      end
    end
  endtask

  task automatic test_single_read();
    logic [19:0] e;
    apply_reset();
    run_txn(1, 1'b0, 8'h04, 8'h00, 8'h59, 0);
    for (int k = 1; k <= TXN + 1; k++) begin
      e = exp_obs(k, 1, 1'b0, 8'h04, 8'h00);
      n_cmp++;
      if ((trace[k] & cmp_mask(e)) !== (e & cmp_mask(e))) begin
        n_bad++; $display("FAIL read_cycle%0d: got %h expected %h", k, trace[k], e);
      end
    end
    n_cmp++;
    if (rdata_at_done !== 8'h59) begin
      n_bad++; $display("FAIL read_rdata: got %h expected 59", rdata_at_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a [NREQ];
    logic [7:0] d [NREQ];
    logic [19:0] e, got;
    int w, k;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 8'($urandom);
      d[i] = 8'($urandom);
      bi.addr[i*DW +: DW]  = a[i];
      bi.wdata[i*DW +: DW] = d[i];
    end
    bi.we  = '1;
    bi.req = '1;
    w = 0;
    for (int c = 1; c <= 4 * (TXN + 1); c++) begin
      @(negedge clk);
      got = obs_main();
      k = (c - 1) % (TXN + 1) + 1;
      if (k == 1) begin
        w = model_winner(bi.req, m_ptr);
        m_ptr = (w + 1) % NREQ;
      end
      e = exp_obs(k, w, 1'b1, a[w], d[w]);
      n_cmp++;
      if ((got & cmp_mask(e)) !== (e & cmp_mask(e))) begin
        n_bad++; $display("FAIL b2b_cycle%0d owner%0d: got %h expected %h", c, w, got, e);
      end
      n_cmp++;
      if ($countones(bi.grant) > 1) begin
        n_bad++; $display("FAIL b2b_onehot cycle%0d: got %b expected at most one bit", c, bi.grant);
      end
    end
    bi.req = '0;
  endtask

  task automatic test_drop_req();
    logic [19:0] e;
    logic [7:0] a, d;
    apply_reset();
    a = 8'($urandom);
    d = 8'($urandom);
    run_txn(2, 1'b1, a, d, 8'h00, TP + 1);
    for (int k = 1; k <= TXN + 1; k++) begin
      e = exp_obs(k, 2, 1'b1, a, d);
      n_cmp++;
      if ((trace[k] & cmp_mask(e)) !== (e & cmp_mask(e))) begin
        n_bad++; $display("FAIL drop_cycle%0d: got %h expected %h", k, trace[k], e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] idle_e, e;
    int n_done;
    apply_reset();
    idle_e = exp_obs(TXN + 1, 0, 1'b0, 8'h00, 8'h00);
    bi.we[0] = 1'b1;
    bi.addr[0 +: DW]  = 8'h33;
    bi.wdata[0 +: DW] = 8'hC4;
    bi.req[0] = 1'b1;
    repeat (TP + TG + 2) @(negedge clk);
    n_cmp++;
    if (bi.wr !== 1'b0 || bi.ad !== 1'b1) begin
      n_bad++; $display("FAIL midrst_in_dat: got wr=%b ad=%b expected wr=0 ad=1", bi.wr, bi.ad);
    end
    rst_n = 1'b0;
    bi.req = '0;
    @(negedge clk);
    n_cmp++;
    if (obs_main() !== idle_e) begin
      n_bad++; $display("FAIL midrst_pins: got %h expected %h", obs_main(), idle_e);
    end
    rst_n = 1'b1;
    m_ptr = 0;
    n_done = 0;
    for (int c = 0; c < TXN + 3; c++) begin
      @(negedge clk);
      if (bi.done != '0 || bi.busy) n_done++;
    end
    n_cmp++;
    if (n_done != 0) begin
      n_bad++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", n_done);
    end
    run_txn(0, 1'b1, 8'h0A, 8'h26, 8'h00, 0);
    for (int k = 1; k <= TXN + 1; k++) begin
      e = exp_obs(k, 0, 1'b1, 8'h0A, 8'h26);
      n_cmp++;
      if ((trace[k] & cmp_mask(e)) !== (e & cmp_mask(e))) begin
        n_bad++; $display("FAIL midrst_after_cycle%0d: got %h expected %h", k, trace[k], e);
      end
    end
  endtask

  task automatic test_random_fast();
    logic            pend [NREQ];
    logic            pwe  [NREQ];
    logic [7:0]      paddr [NREQ];
    logic [7:0]      pwdat [NREQ];
    logic            outst [NREQ];
    logic [NREQ-1:0] req_prev;
    logic            owe;
    logic [7:0]      oaddr, owdat, exp_rd;
    int owner, w, n_grant, n_done, left;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; outst[i] = 1'b0; pwe[i] = 1'b0; paddr[i] = '0; pwdat[i] = '0;
    end
    owner = -1; n_grant = 0; n_done = 0; req_prev = '0;
    owe = 1'b0; oaddr = '0; owdat = '0; exp_rd = '0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bf.cs && !(bf.rd && bf.wr && bf.ad)) begin
        n_bad++; $display("FAIL inv_cs c%0d: got rd=%b wr=%b ad=%b expected all 1", c, bf.rd, bf.wr, bf.ad);
      end
      n_cmp++;
      if (!bf.rd && !bf.wr) begin
        n_bad++; $display("FAIL inv_rdwr c%0d: got rd=0 wr=0 expected not both low", c);
      end
      n_cmp++;
      if (!bf.rd && bf.bus_oe) begin
        n_bad++; $display("FAIL inv_oe c%0d: got bus_oe=1 expected 0 while rd low", c);
      end
      n_cmp++;
      if ($countones(bf.grant) > 1) begin
        n_bad++; $display("FAIL rnd_onehot c%0d: got %b expected at most one bit", c, bf.grant);
      end
      if (bf.grant != '0 && owner < 0) begin
        w = model_winner(req_prev, f_ptr);
        if (w < 0) w = 0;
        f_ptr = (w + 1) % NREQ;
        n_cmp++;
        if (bf.grant !== onehot(w)) begin
          n_bad++; $display("FAIL rnd_grant c%0d: got %b expected %b", c, bf.grant, onehot(w));
        end
        n_cmp++;
        if (outst[w]) begin
          n_bad++; $display("FAIL rnd_regrant c%0d: got second grant to %0d expected done first", c, w);
        end
        outst[w] = 1'b1; owner = w; n_grant++;
        owe = pwe[w]; oaddr = paddr[w]; owdat = pwdat[w];
      end
      if (owner >= 0 && !bf.ad) begin
        n_cmp++;
        if (bf.bus_out !== oaddr) begin
          n_bad++; $display("FAIL rnd_addr c%0d: got %h expected %h", c, bf.bus_out, oaddr);
        end
      end
      if (owner >= 0 && !bf.wr && bf.ad) begin
        n_cmp++;
        if (bf.bus_out !== owdat) begin
          n_bad++; $display("FAIL rnd_wdata c%0d: got %h expected %h", c, bf.bus_out, owdat);
        end
      end
      if (bf.done != '0) begin
        n_cmp++;
        if (owner < 0 || bf.done !== onehot(owner < 0 ? 0 : owner)) begin
          n_bad++; $display("FAIL rnd_done c%0d: got %b expected owner %0d", c, bf.done, owner);
        end
        if (owner >= 0 && !owe) begin
          n_cmp++;
          if (bf.rdata !== exp_rd) begin
            n_bad++; $display("FAIL rnd_rdata c%0d: got %h expected %h", c, bf.rdata, exp_rd);
          end
        end
        for (int i = 0; i < NREQ; i++) begin
          if (bf.done[i]) begin
            n_cmp++;
            if (!outst[i]) begin
              n_bad++; $display("FAIL rnd_spurious_done c%0d: got done to %0d expected none", c, i);
            end
            outst[i] = 1'b0; pend[i] = 1'b0; bf.req[i] = 1'b0; n_done++;
          end
        end
      end
      if (bf.grant == '0) owner = -1;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && c < 1960 && $urandom_range(0, 3) == 0) begin
          pend[i]  = 1'b1;
          pwe[i]   = 1'($urandom);
          paddr[i] = 8'($urandom);
          pwdat[i] = 8'($urandom);
          bf.we[i] = pwe[i];
          bf.addr[i*DW +: DW]  = paddr[i];
          bf.wdata[i*DW +: DW] = pwdat[i];
          bf.req[i] = 1'b1;
        end
      end
      bf.bus_in = 8'($urandom);
      if (!bf.rd) exp_rd = bf.bus_in;
      req_prev = bf.req;
    end
    left = 0;
    for (int i = 0; i < NREQ; i++) if (pend[i] || outst[i]) left++;
    n_cmp++;
    if (left != 0) begin
      n_bad++; $display("FAIL rnd_unserved: got %0d requesters waiting expected 0", left);
    end
    n_cmp++;
    if (n_grant != n_done || n_grant == 0) begin
      n_bad++; $display("FAIL rnd_done_count: got %0d dones for %0d grants expected equal and nonzero", n_done, n_grant);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_drop_req();
    test_reset_mid();
    test_random_fast();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
- Arbitrates NREQ requesters (write-time, read-time, alarm/load engines) for the single multiplexed address/data RTC bus.
- Sequences each granted transaction as a complete Intel-style bus cycle: an address phase on cs/ad/wr, then a data phase on cs/wr or cs/rd.
- Replaces per-source strobe generation and the static strobe mux; requesters only present req/we/addr/wdata and wait for done.
- Sits between the RTC access engines and the top-level RTC pins/tristate buffer.

Parameters:
- NREQ, 3, number of requesters (index 0..NREQ-1).
- DW, 8, address/data bus width.
- T_PULSE, 4, strobe low width in clk cycles (>=1).
- T_GAP, 2, hold/recovery width in clk cycles (>=1).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous reset, active-low.
- req  in  NREQ  per-requester transaction request, level, held until done.
- we  in  NREQ  per-requester 1=write, 0=read.
- addr  in  NREQ*DW  packed register addresses, requester i at [i*DW +: DW].
- wdata  in  NREQ*DW  packed write data, same packing.
- done  out  NREQ  one-cycle pulse to the served requester at transaction end.
- rdata  out  DW  last read data, shared by all requesters, valid from done onward.
- grant  out  NREQ  one-hot current owner, 0 when idle.
- busy  out  1  high whenever state != IDLE.
- cs, rd, wr, ad  out  1 each  RTC strobes, active-low.
- bus_out  out  DW  value driven onto the RTC AD bus.
- bus_oe  out  1  tristate enable for bus_out.
- bus_in  in  DW  RTC AD bus read-back.

Behaviour:
- Reset (rst_n=0 at posedge):
  - cs=rd=wr=ad=1; bus_oe=0; bus_out=0; grant=0; done=0; busy=0; rdata=0; state=IDLE; round-robin pointer=0.
  - Reset mid-transaction aborts the cycle; strobes are high at the next edge and no done is issued.
- All outputs are registered.
- States: IDLE -> ADR -> AHOLD -> DAT -> RCV -> IDLE.
- IDLE:
  - Strobes high, bus_oe=0.
  - If any req bit is set, latch the winner's index, we, addr and wdata, set grant, and go to ADR on the next edge.
  - Latched values are immune to later input changes.
- ADR, T_PULSE cycles: cs=0, ad=0, wr=0, bus_oe=1, bus_out=addr.
- AHOLD, T_GAP cycles: cs=0, ad=1, wr=1, rd=1, bus_oe=1, bus_out=addr.
- DAT, T_PULSE cycles:
  - Write: cs=0, wr=0, bus_oe=1, bus_out=wdata.
  - Read: cs=0, rd=0, bus_oe=0; rdata captures bus_in on the last DAT cycle.
- RCV, T_GAP cycles:
  - All strobes high, bus_oe=0.
  - done[grant] pulses on the last RCV cycle; grant clears on entry to IDLE.
- Phase timing:
  - A single down-counter, width $clog2(max(T_PULSE,T_GAP)+1), loads T-1 on phase entry; the phase advances when it reaches 0.
  - Total transaction length = 2*T_PULSE + 2*T_GAP cycles from ADR entry; default 12.
  - The next grant can start in the cycle after return to IDLE, giving 1 idle cycle between back-to-back transactions.
- Arbitration:
  - Round-robin; the search starts at pointer, and pointer becomes winner+1 (mod NREQ) when a grant is made.
  - Simultaneous requests never produce more than one grant.
- req dropped mid-transaction: the transaction completes normally and done still pulses. A requester re-asserting req in the same cycle as its done is treated as a new request.
- Invariants:
  - cs=1 implies rd=wr=ad=1.
  - rd and wr are never low together.
  - bus_oe=0 whenever rd=0.

Optional Feature:
- Macro: RTC_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; pointer logic removed.
- Undefined: round-robin as above.
- Bus timing is identical in both builds.

Decomposition:
- Package rtc_bus_pkg holds:
  - state enum (IDLE, ADR, AHOLD, DAT, RCV);
  - default T_PULSE/T_GAP constants;
  - a function computing counter width.
- One sub-module, rtc_rr_arbiter (req, pointer -> one-hot winner, index, any). The RTC_FIXED_PRIO_EN selection lives inside it.

Test Plan:
- Single write from requester 0, addr=0x0A, wdata=0x26 -> ad/wr low for cycles 1-4 with bus_out=0x0A; wr low for cycles 7-10 with bus_out=0x26; done[0] at cycle 12; busy high for cycles 1-12.
- Single read from requester 1, addr=0x04, bus_in=0x59 during DAT -> rd low for 4 cycles, bus_oe=0 in DAT, rdata=0x59 at done[1]; wr stays high throughout DAT.
- req=3'b111 held continuously -> grants 0,1,2,0 in order (fixed-prio build: 0,0,0); one-hot grant and no overlapping strobes.
- Requester 2 drops req during AHOLD and changes addr -> cycle completes with the latched addr, and done[2] pulses.
- rst_n low during DAT of a write -> next edge cs=wr=rd=ad=1, bus_oe=0, no done; a fresh request after reset completes normally.
- Invariant checker run under random req/we over 2000 cycles with T_PULSE=1, T_GAP=1 -> invariants hold, and every accepted request receives exactly one done.
